div_rem_sequencer: RTL and testbench

- Multi-cycle sequencer and iterative datapath for the ALU's signed div (Alu_Control 4'b0100) and rem (4'b0101) operations.
- Sits beside the ALU and asserts a stall to hold the PC and register-file write until the result is ready.
- The core ALU stays single-cycle; the core's result mux selects result_o whenever div or rem is decoded.
- Uses RISC-V signed semantics.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_rem_sequencer_if.sv | 24 ++
 rtl/div_rem_sequencer_div_step.sv | 26 ++
 rtl/div_rem_sequencer.sv | 126 ++++++++++++
 tb/tb_div_rem_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the div/rem sequencer.
package div_pkg;

    localparam int unsigned DIV_XLEN = 32;

    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_REM = 4'b0101;

    localparam logic [DIV_XLEN-1:0] INT_MIN = DIV_XLEN'(1) << (DIV_XLEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_rem_sequencer_if.sv
// Handshake/operand bundle between the core decode stage and the div/rem sequencer.
interface div_rem_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [3:0]      alu_ctrl_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            abort_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, alu_ctrl_i, dividend_i, divisor_i, abort_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, alu_ctrl_i, dividend_i, divisor_i, abort_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_rem_sequencer_div_step.sv
// One combinational restoring-division step on the {rem,quo} pair.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Extra top bit keeps the trial subtraction's borrow visible.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_rem_sequencer.sv
// Multi-cycle signed div/rem sequencer that stalls the core until the result is ready.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, overflow and zero dividend bypass PREP/ITER.
module div_rem_sequencer
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    div_rem_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] SIGN_ONLY = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic              op_rem;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result_r;

    logic              valid_op;
    logic              start_ok;
    logic [XLEN-1:0]   abs_a_in;
    logic [XLEN-1:0]   abs_b_in;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   dividend_val;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   fix_result;
    logic              early;

    assign valid_op = (bus.alu_ctrl_i == ALU_DIV) || (bus.alu_ctrl_i == ALU_REM);
    assign start_ok = bus.start_i && valid_op && !bus.abort_i;
    assign abs_a_in = bus.dividend_i[XLEN-1] ? -bus.dividend_i : bus.dividend_i;
    assign abs_b_in = bus.divisor_i[XLEN-1]  ? -bus.divisor_i  : bus.divisor_i;

`ifdef DIV_EARLY_OUT_EN
    assign early = (bus.divisor_i == '0) || (bus.dividend_i == '0) ||
                   ((bus.dividend_i == SIGN_ONLY) && (bus.divisor_i == '1));
`else
    assign early = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (abs_b),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Special cases are resolved here so early-out and full paths share one result.
    always_comb begin
        dividend_val = sign_a ? -abs_a : abs_a;
        quo_signed   = (sign_a ^ sign_b) ? -quo_r : quo_r;
        rem_signed   = sign_a ? -rem_r : rem_r;
        if (abs_b == '0)
            fix_result = op_rem ? dividend_val : '1;
        else if ((dividend_val == SIGN_ONLY) && sign_b && (abs_b == XLEN'(1)))
            fix_result = op_rem ? '0 : SIGN_ONLY;
        else
            fix_result = op_rem ? rem_signed : quo_signed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_rem   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            abs_a    <= '0;
            abs_b    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else if (bus.abort_i && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    op_rem <= (bus.alu_ctrl_i == ALU_REM);
                    sign_a <= bus.dividend_i[XLEN-1];
                    sign_b <= bus.divisor_i[XLEN-1];
                    abs_a  <= abs_a_in;
                    abs_b  <= abs_b_in;
                    rem_r  <= '0;
                    quo_r  <= abs_a_in;
                    cnt    <= '0;
                    state  <= early ? FIX : PREP;
                end
                PREP: begin
                    rem_r <= '0;
                    quo_r <= abs_a;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    rem_r <= rem_next;
                    quo_r <= quo_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    result_r <= fix_result;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = (state == DONE);
    assign bus.stall_o  = (state == IDLE) ? (bus.start_i && valid_op) : (state != DONE);
    assign bus.result_o = result_r;

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Bench for div_rem_sequencer: vector table with a result scoreboard plus abort/reset sequences.
module tb_div_rem_sequencer;
    import div_pkg::*;

    localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = FULL_LAT;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    vec_t vecs[11];

    div_rem_sequencer_if #(.XLEN(32)) bus ();

    div_rem_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = (b == 32'd0) || (a == 32'd0) || ((a == INT_MIN) && (b == 32'hFFFF_FFFF));
        return sp ? EARLY_LAT : FULL_LAT;
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   edges;
        bit   seen;
        bit   stall_ok;
        logic [31:0] want;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.alu_ctrl_i = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        exp_q.push_back(exp);
        @(posedge clk);
        edges = 0;
        seen = 0;
        stall_ok = 1;
        while (!seen && edges < 200) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1;
            end else begin
                if (bus.stall_o !== 1'b1) stall_ok = 0;
                @(posedge clk);
                edges++;
            end
        end
        if (!seen) begin
            check({name, " timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            if (exp_q.size() == 0) begin
                check({name, " unexpected done"}, 32'd1, 32'd0);
            end else begin
                want = exp_q.pop_front();
                check({name, " result"}, bus.result_o, want);
                last_res = want;
            end
            check({name, " latency"}, 32'(edges), 32'(exp_lat(a, b)));
            check({name, " stall held"}, {31'd0, stall_ok}, 32'd1);
            check({name, " stall low in done"}, {31'd0, bus.stall_o}, 32'd0);
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{ALU_DIV, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{ALU_REM, -32'sd100,      32'd7,          32'hFFFF_FFFE};
        vecs[2]  = '{ALU_DIV, -32'sd100,      32'd7,          -32'sd14};
        vecs[3]  = '{ALU_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[4]  = '{ALU_REM, 32'd5,          32'd0,          32'd5};
        vecs[5]  = '{ALU_DIV, INT_MIN,        32'hFFFF_FFFF,  INT_MIN};
        vecs[6]  = '{ALU_REM, INT_MIN,        32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{ALU_REM, 32'd7,          -32'sd3,        32'd1};
        vecs[8]  = '{ALU_DIV, -32'sd7,        -32'sd3,        32'd2};
        vecs[9]  = '{ALU_DIV, 32'd0,          32'd5,          32'd0};
        vecs[10] = '{ALU_REM, -32'sd5,        32'd0,          -32'sd5};

        bus.start_i    = 1'b0;
        bus.alu_ctrl_i = 4'd0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.abort_i    = 1'b0;
        last_res       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset result", bus.result_o, 32'd0);
        check("reset flags", {29'd0, bus.done_o, bus.busy_o, bus.stall_o}, 32'd0);
        rst_n = 1'b1;

        // Non-div/rem codes must not start anything.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.alu_ctrl_i = 4'b0010;
        check("illegal op stall", {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("illegal op busy", {31'd0, bus.busy_o}, 32'd0);
        bus.start_i = 1'b0;

        // Consecutive calls present the next op in the IDLE cycle after DONE.
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        @(negedge clk);
        check("done single pulse", {30'd0, bus.done_o, bus.busy_o}, 32'd0);

        // Abort in the 10th ITER cycle.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.alu_ctrl_i = ALU_DIV;
        bus.dividend_i = 32'd50;
        bus.divisor_i = 32'd5;
        exp_q.push_back(32'd10);
        @(posedge clk);
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("abort pre busy", {31'd0, bus.busy_o}, 32'd1);
        bus.abort_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.abort_i = 1'b0;
        void'(exp_q.pop_front());
        check("abort flags", {29'd0, bus.done_o, bus.busy_o, bus.stall_o}, 32'd0);
        check("abort keeps result", bus.result_o, last_res);
        begin
            bit any_done = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.done_o) any_done = 1;
            end
            check("abort no done", {31'd0, any_done}, 32'd0);
        end
        run_op("rem after abort", ALU_REM, 32'd50, 32'd6, 32'd2);

        // Abort wins over start in IDLE.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.alu_ctrl_i = ALU_DIV;
        bus.abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort priority busy", {31'd0, bus.busy_o}, 32'd0);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;

        // Reset in the 20th ITER cycle.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.alu_ctrl_i = ALU_DIV;
        bus.dividend_i = 32'd1000;
        bus.divisor_i = 32'd3;
        exp_q.push_back(32'd333);
        @(posedge clk);
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        void'(exp_q.pop_front());
        check("mid reset result", bus.result_o, 32'd0);
        check("mid reset flags", {29'd0, bus.done_o, bus.busy_o, bus.stall_o}, 32'd0);
        rst_n = 1'b1;
        run_op("div after reset", ALU_DIV, 32'd9, 32'd3, 32'd3);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
